// File: rtl/buzzer_scheduler.sv
// Buzzer owner for the alarm clock: arbitrates alarm ring (with snooze), hourly chime and key click
// onto one piezo pin as a CLK_HZ/2 square wave.
module buzzer_scheduler #(
   parameter int unsigned CLK_HZ      = 2048,
   parameter int unsigned ALARM_SECS  = 20,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter int unsigned SNOOZE_MAX  = 3,
   parameter int unsigned KEY_CYC     = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sec_tick,
   input  logic [7:0] min_bcd,
   input  logic [7:0] sec_bcd,
   input  logic       alarm_en,
   input  logic       alarm_hit,
   input  logic       chime_en,
   input  logic       stop_key,
   input  logic       snooze_key,
   input  logic       key_press,
   output logic       buzz,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] src
);

   localparam int unsigned SEC_MAX = (ALARM_SECS > SNOOZE_SECS) ? ALARM_SECS : SNOOZE_SECS;
   localparam int unsigned PH_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned SC_W    = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;
   localparam int unsigned SN_W    = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;
   localparam int unsigned CK_W    = (KEY_CYC > 0) ? $clog2(KEY_CYC + 1) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RING   = 2'd1;
   localparam logic [1:0] SNOOZE = 2'd2;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_KEY   = 2'd1;
   localparam logic [1:0] SRC_CHIME = 2'd2;
   localparam logic [1:0] SRC_ALARM = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [SC_W-1:0] sec_cnt_q, sec_cnt_d;
   logic [SN_W-1:0] snooze_cnt_q, snooze_cnt_d;
   logic [CK_W-1:0] click_cnt_q, click_cnt_d;
   logic            buzz_q, buzz_d;
   logic            ringing_q, ringing_d;
   logic            snoozing_q, snoozing_d;
   logic [1:0]      src_q, src_d;

   logic first_half, alarm_gate, chime_gate, click_gate, any_gate;

   // State register and all output flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         phase_q      <= '0;
         sec_cnt_q    <= '0;
         snooze_cnt_q <= '0;
         click_cnt_q  <= '0;
         buzz_q       <= 1'b0;
         ringing_q    <= 1'b0;
         snoozing_q   <= 1'b0;
         src_q        <= SRC_NONE;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         sec_cnt_q    <= sec_cnt_d;
         snooze_cnt_q <= snooze_cnt_d;
         click_cnt_q  <= click_cnt_d;
         buzz_q       <= buzz_d;
         ringing_q    <= ringing_d;
         snoozing_q   <= snoozing_d;
         src_q        <= src_d;
      end
   end

   // Alarm FSM: ring/snooze timing and snooze budget
   always_comb begin
      state_d      = state_q;
      sec_cnt_d    = sec_cnt_q;
      snooze_cnt_d = snooze_cnt_q;
      case (state_q)
         IDLE: begin
            if (alarm_hit && alarm_en) begin
               state_d   = RING;
               sec_cnt_d = '0;
            end
         end
         RING: begin
            if (!alarm_en || stop_key || (snooze_key && snooze_cnt_q >= SN_W'(SNOOZE_MAX))) begin
               state_d      = IDLE;
               snooze_cnt_d = '0;
            end else if (snooze_key) begin
               state_d      = SNOOZE;
               sec_cnt_d    = '0;
               snooze_cnt_d = snooze_cnt_q + SN_W'(1);
            end else if (sec_tick) begin
               if (sec_cnt_q == SC_W'(ALARM_SECS - 1)) begin
                  state_d      = IDLE;
                  snooze_cnt_d = '0;
               end else begin
                  sec_cnt_d = sec_cnt_q + SC_W'(1);
               end
            end
         end
         SNOOZE: begin
            if (!alarm_en || stop_key) begin
               state_d      = IDLE;
               snooze_cnt_d = '0;
            end else if (sec_tick) begin
               if (sec_cnt_q == SC_W'(SNOOZE_SECS - 1)) begin
                  state_d   = RING;
                  sec_cnt_d = '0;
               end else begin
                  sec_cnt_d = sec_cnt_q + SC_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Tone gates, click timer, arbitration and square-wave drive
   always_comb begin
      first_half = phase_q < PH_W'(CLK_HZ / 2);
      alarm_gate = (state_q == RING) && first_half;
      chime_gate = chime_en && (state_q != RING) &&
                   ((min_bcd == 8'h59 && sec_bcd >= 8'h55 && sec_bcd <= 8'h59 && first_half) ||
                    (min_bcd == 8'h00 && sec_bcd == 8'h00));
      click_gate = click_cnt_q != '0;
      any_gate   = alarm_gate || chime_gate || click_gate;

      phase_d = phase_q;
      if (sec_tick) begin
         phase_d = '0;
      end else if (phase_q != PH_W'(CLK_HZ - 1)) begin
         phase_d = phase_q + PH_W'(1);
      end

      click_cnt_d = click_cnt_q;
      if (alarm_gate || chime_gate) begin
         click_cnt_d = '0;
      end else if (key_press && state_q != RING) begin
         click_cnt_d = CK_W'(KEY_CYC);
      end else if (click_gate) begin
         click_cnt_d = click_cnt_q - CK_W'(1);
      end

      // The alarm owns the buzzer for the whole ring, including its silent half-seconds
      if (state_q == RING) begin
         src_d = SRC_ALARM;
      end else if (chime_gate) begin
         src_d = SRC_CHIME;
      end else if (click_gate) begin
         src_d = SRC_KEY;
      end else begin
         src_d = SRC_NONE;
      end

      buzz_d     = any_gate ? ~buzz_q : 1'b0;
      ringing_d  = state_d == RING;
      snoozing_d = state_d == SNOOZE;
   end

   assign buzz     = buzz_q;
   assign ringing  = ringing_q;
   assign snoozing = snoozing_q;
   assign src      = src_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: per-cycle comparison against a time/mode model plus literal
// expectations for beep counts, ownership and alarm/snooze sequencing.
module tb_buzzer_scheduler;

   localparam int CLK = 8;
   localparam int AS  = 3;
   localparam int SS  = 4;
   localparam int SM  = 2;
   localparam int KC  = 2;

   logic       clk = 1'b0;
   logic       rst_n, sec_tick, alarm_en, alarm_hit, chime_en, stop_key, snooze_key, key_press;
   logic [7:0] min_bcd, sec_bcd;
   logic       buzz, ringing, snoozing;
   logic [1:0] src;

   int total = 0;
   int bad   = 0;

   buzzer_scheduler #(
      .CLK_HZ(CLK), .ALARM_SECS(AS), .SNOOZE_SECS(SS), .SNOOZE_MAX(SM), .KEY_CYC(KC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
      .alarm_en(alarm_en), .alarm_hit(alarm_hit), .chime_en(chime_en), .stop_key(stop_key),
      .snooze_key(snooze_key), .key_press(key_press), .buzz(buzz), .ringing(ringing),
      .snoozing(snoozing), .src(src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Model: mode 0 idle, 1 ringing, 2 snoozing; m_left = seconds remaining in the current mode
   int   m_mode = 0, m_left = 0, m_snz = 0, m_phase = 0, m_click = 0;
   int   mn, sc;
   bit   m_first, m_ag, m_cg, m_kg;
   logic m_buzz = 1'b0, m_ring = 1'b0, m_snzg = 1'b0;
   int   m_src = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_left = 0; m_snz = 0; m_phase = 0; m_click = 0;
         m_buzz = 1'b0; m_ring = 1'b0; m_snzg = 1'b0; m_src = 0;
      end else begin
         mn      = bcd2int(min_bcd);
         sc      = bcd2int(sec_bcd);
         m_first = m_phase < CLK / 2;
         m_ag    = (m_mode == 1) && m_first;
         m_cg    = chime_en && (m_mode != 1) &&
                   ((mn == 59 && sc >= 55 && m_first) || (mn == 0 && sc == 0));
         m_kg    = m_click > 0;
         m_src   = (m_mode == 1) ? 3 : m_cg ? 2 : m_kg ? 1 : 0;
         m_buzz  = (m_ag || m_cg || m_kg) ? !m_buzz : 1'b0;
         if (m_ag || m_cg) m_click = 0;
         else if (key_press && m_mode != 1) m_click = KC;
         else if (m_click > 0) m_click--;
         if (sec_tick) m_phase = 0;
         else if (m_phase < CLK - 1) m_phase++;
         case (m_mode)
            0: if (alarm_hit && alarm_en) begin m_mode = 1; m_left = AS; end
            1: begin
               if (!alarm_en || stop_key) begin m_mode = 0; m_snz = 0; end
               else if (snooze_key) begin
                  if (m_snz < SM) begin m_mode = 2; m_left = SS; m_snz++; end
                  else begin m_mode = 0; m_snz = 0; end
               end else if (sec_tick) begin
                  m_left--;
                  if (m_left == 0) begin m_mode = 0; m_snz = 0; end
               end
            end
            default: begin
               if (!alarm_en || stop_key) begin m_mode = 0; m_snz = 0; end
               else if (sec_tick) begin
                  m_left--;
                  if (m_left == 0) begin m_mode = 1; m_left = AS; end
               end
            end
         endcase
         m_ring = m_mode == 1;
         m_snzg = m_mode == 2;
      end
   end

   int   hi_cnt = 0, src1_cnt = 0, src2_cnt = 0, src3_cnt = 0, snz_entries = 0;
   logic snz_prev = 1'b0;

   // Compare process plus event counters, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         chk("buzz", int'(buzz), int'(m_buzz));
         chk("ringing", int'(ringing), int'(m_ring));
         chk("snoozing", int'(snoozing), int'(m_snzg));
         chk("src", int'(src), m_src);
         if (buzz) hi_cnt++;
         if (src == 2'd1) src1_cnt++;
         if (src == 2'd2) src2_cnt++;
         if (src == 2'd3) src3_cnt++;
         if (snoozing && !snz_prev) snz_entries++;
         snz_prev = snoozing;
      end
   end

   int tmin = 12, tsec = 0, cyc = 0;

   task automatic drive_time();
      min_bcd = 8'((tmin / 10) * 16 + tmin % 10);
      sec_bcd = 8'((tsec / 10) * 16 + tsec % 10);
   endtask

   // One clock: clears pulses, advances the wall clock and raises sec_tick every CLK cycles
   task automatic step();
      @(posedge clk);
      #1;
      sec_tick = 0; alarm_hit = 0; stop_key = 0; snooze_key = 0; key_press = 0;
      cyc++;
      if (cyc == CLK) begin
         cyc = 0;
         tsec++;
         if (tsec == 60) begin tsec = 0; tmin = (tmin + 1) % 60; end
         sec_tick = 1;
      end
      drive_time();
   endtask

   task automatic to_tick();
      do step(); while (!sec_tick);
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wait_ring(input int budget);
      int n = 0;
      while (!ringing && n < budget) begin step(); n++; end
      chk("wait_ring", int'(ringing), 1);
   endtask

   task automatic wait_buzz(input int budget);
      int n = 0;
      while (!buzz && n < budget) begin step(); n++; end
      chk("wait_buzz", int'(buzz), 1);
   endtask

   initial begin
      rst_n = 0; sec_tick = 0; alarm_en = 0; alarm_hit = 0; chime_en = 0;
      stop_key = 0; snooze_key = 0; key_press = 0;
      drive_time();
      steps(3);
      @(negedge clk);
      chk("rst_buzz", int'(buzz), 0);
      chk("rst_ringing", int'(ringing), 0);
      chk("rst_snoozing", int'(snoozing), 0);
      chk("rst_src", int'(src), 0);
      step();
      rst_n = 1;
      steps(4);

      // Plain alarm: 3 s of 0.5 s on / 0.5 s off, then auto-stop
      alarm_en = 1;
      to_tick(); alarm_hit = 1; step();
      hi_cnt = 0;
      @(negedge clk); chk("ring_enter", int'(ringing), 1);
      step(); @(negedge clk); chk("ring_src", int'(src), 3);
      steps(23);
      chk("ring_highs", hi_cnt, 6);
      @(negedge clk); chk("ring_autostop", int'(ringing), 0);
      step(); @(negedge clk); chk("ring_src_clear", int'(src), 0);
      steps(5);

      // Snooze budget: two snoozes, third acts as stop
      snz_entries = 0;
      to_tick(); alarm_hit = 1; step(); step();
      snooze_key = 1; step();
      @(negedge clk); chk("snz1_enter", int'(snoozing), 1);
      wait_ring(80);
      snooze_key = 1; step();
      wait_ring(80);
      snooze_key = 1; step();
      @(negedge clk);
      chk("snz3_ring", int'(ringing), 0);
      chk("snz3_snoozing", int'(snoozing), 0);
      steps(40);
      chk("snz_entries", snz_entries, 2);

      // Chime: five short beeps from 59:55, long beep at 00:00
      alarm_en = 0; chime_en = 1;
      to_tick(); tmin = 59; tsec = 53; drive_time();
      hi_cnt = 0; src2_cnt = 0;
      steps(65);
      chk("chime_highs", hi_cnt, 14);
      chk("chime_src2", src2_cnt, 28);
      chime_en = 0;
      to_tick(); tmin = 59; tsec = 53; drive_time();
      hi_cnt = 0;
      steps(65);
      chk("chime_off_highs", hi_cnt, 0);

      // Chime suppressed while ringing
      alarm_en = 1; chime_en = 1;
      to_tick(); tmin = 59; tsec = 56; drive_time(); alarm_hit = 1; step();
      hi_cnt = 0; src3_cnt = 0;
      steps(25);
      chk("ring_chime_src3", src3_cnt, 24);
      chk("ring_chime_highs", hi_cnt, 6);
      steps(20);
      chime_en = 0;

      // Simultaneous stop+snooze stops and clears the snooze budget
      to_tick(); alarm_hit = 1; step(); step();
      snooze_key = 1; step();
      wait_ring(80);
      stop_key = 1; snooze_key = 1; step();
      @(negedge clk);
      chk("stopsnz_ring", int'(ringing), 0);
      chk("stopsnz_snz", int'(snoozing), 0);
      to_tick(); alarm_hit = 1; step();
      snooze_key = 1; step();
      @(negedge clk); chk("budget_a", int'(snoozing), 1);
      wait_ring(80);
      snooze_key = 1; step();
      @(negedge clk); chk("budget_b", int'(snoozing), 1);
      stop_key = 1; step();
      steps(3);

      // Key click in idle, blocked while ringing
      hi_cnt = 0; src1_cnt = 0;
      key_press = 1;
      steps(5);
      chk("click_highs", hi_cnt, 1);
      chk("click_src1", src1_cnt, 2);
      to_tick(); alarm_hit = 1; step();
      steps(4);
      key_press = 1; hi_cnt = 0;
      steps(3);
      chk("click_in_ring", hi_cnt, 0);
      stop_key = 1; step();
      steps(3);

      // Click allowed while snoozing; alarm_en drop leaves snooze
      to_tick(); alarm_hit = 1; step();
      snooze_key = 1; step();
      key_press = 1; step();
      steps(3);
      @(negedge clk); chk("snz_before_drop", int'(snoozing), 1);
      alarm_en = 0; step();
      @(negedge clk);
      chk("drop_snz", int'(snoozing), 0);
      chk("drop_ring", int'(ringing), 0);
      alarm_en = 1;
      steps(3);

      // alarm_hit beats stop_key in idle
      alarm_hit = 1; stop_key = 1; step();
      @(negedge clk); chk("hit_over_stop", int'(ringing), 1);
      stop_key = 1; step();
      steps(3);

      // Async reset mid-ring clears outputs immediately and forgets snoozes
      to_tick(); alarm_hit = 1; step();
      snooze_key = 1; step();
      wait_ring(80);
      wait_buzz(20);
      #2 rst_n = 0;
      #1;
      chk("arst_buzz", int'(buzz), 0);
      chk("arst_ringing", int'(ringing), 0);
      chk("arst_src", int'(src), 0);
      steps(2);
      rst_n = 1;
      steps(2);
      to_tick(); alarm_hit = 1; step();
      snooze_key = 1; step();
      @(negedge clk); chk("arst_snz_a", int'(snoozing), 1);
      wait_ring(80);
      snooze_key = 1; step();
      @(negedge clk); chk("arst_snz_b", int'(snoozing), 1);
      stop_key = 1; step();
      steps(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
